// File: rtl/data_mem_bridge.sv
// Single-outstanding bridge between the memory controller stage and a req/gnt/rvalid data bus.
// Optional response watchdog enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_exception,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        timeout;
    logic        we_q;
    logic [3:0]  mask_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    assign accept = (req_read | req_write) & ~req_exception;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    // Counter is held at zero in IDLE, so it starts from zero on every entry to REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 16'd0;
        end else if (state == REQ || state == WAIT_RSP) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    assign timeout = (state == REQ || state == WAIT_RSP) &&
                     (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // A response arriving in the same cycle as expiry wins over the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout && !(state == WAIT_RSP && bus_rvalid);
        end
    end

    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_be    = 4'b0000;
        case (state)
            IDLE: begin
                stall = accept & rst_n;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                bus_we  = we_q;
                bus_be  = mask_q;
                if (timeout)      state_nxt = DONE;
                else if (bus_gnt) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (bus_rvalid || timeout) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            mask_q  <= 4'b0000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (state == IDLE && accept) begin
            we_q    <= req_write;
            mask_q  <= req_mask;
            addr_q  <= {req_addr[31:2], 2'b00};
            wdata_q <= req_wdata;
        end
    end

    // Writes leave the returned word untouched; a timed-out read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (!we_q) begin
            if (state == WAIT_RSP && bus_rvalid) begin
                rdata_q <= bus_rdata;
            end else if (timeout) begin
                rdata_q <= 32'd0;
            end
        end
    end

    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: per-transaction timeline model plus per-cycle compare.
module tb_data_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TB_T = 4;
`else
    localparam int TB_T = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0, req_exception = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic        stall, done, bus_req, bus_we, bus_err;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    data_mem_bridge #(.TIMEOUT_CYCLES(TB_T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write), .req_exception(req_exception),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .stall(stall), .done(done), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_bus_req, exp_bus_we, exp_bus_err;
    logic [3:0]  exp_bus_be;
    logic [31:0] exp_rdata, exp_bus_addr, exp_bus_wdata;

    // architectural state the model carries between transactions
    logic [31:0] model_addr = '0, model_wdata = '0, model_rdata = '0;

    // request presented during the DONE cycle of a transaction (back-to-back case)
    logic        nx_rd = 0, nx_wr = 0;
    logic [31:0] nx_addr = '0, nx_wdata = '0;
    logic [3:0]  nx_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",     {31'd0, stall},   {31'd0, exp_stall});
            chk("done",      {31'd0, done},    {31'd0, exp_done});
            chk("bus_req",   {31'd0, bus_req}, {31'd0, exp_bus_req});
            chk("bus_we",    {31'd0, bus_we},  {31'd0, exp_bus_we});
            chk("bus_err",   {31'd0, bus_err}, {31'd0, exp_bus_err});
            chk("bus_be",    {28'd0, bus_be},  {28'd0, exp_bus_be});
            chk("rdata",     rdata,     exp_rdata);
            chk("bus_addr",  bus_addr,  exp_bus_addr);
            chk("bus_wdata", bus_wdata, exp_bus_wdata);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic exc,
                             input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        req_read = rd; req_write = wr; req_exception = exc;
        req_addr = a; req_wdata = wd; req_mask = m;
    endtask

    task automatic arm_next(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m);
        nx_rd = rd; nx_wr = wr; nx_addr = a; nx_wdata = wd; nx_mask = m;
    endtask

    // One access, starting in an IDLE cycle (k=0). g = cycles bus_gnt is withheld in REQ,
    // r = cycles bus_rvalid is withheld in WAIT_RSP (negative = never).
    task automatic run_txn(input logic rd, input logic wr, input logic exc,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                           input int g, input int r, input logic [31:0] rbus, input bit keep_next);
        bit accepted, we, err;
        int d, natural;
        logic [31:0] lat_addr;
        accepted = (rd | wr) & ~exc;
        we = wr;
        lat_addr = {a[31:2], 2'b00};
        if (!accepted) begin
            for (int k = 0; k < 3; k++) begin
                drive_req(rd, wr, exc, a, wd, m);
                exp_stall = 0; exp_done = 0; exp_bus_req = 0; exp_bus_we = 0;
                exp_bus_err = 0; exp_bus_be = 4'b0;
                exp_rdata = model_rdata; exp_bus_addr = model_addr; exp_bus_wdata = model_wdata;
                chk_en = 1;
                next_cycle();
            end
            drive_req(0, 0, 0, 0, 0, 0);
            return;
        end
        natural = (r < 0) ? 1000000 : 3 + g + r;
        d = natural;
        err = 0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        if (1 + TB_T < natural) begin
            d = 1 + TB_T;
            err = 1;
        end
`endif
        for (int k = 0; k <= d; k++) begin
            if (k == 0)                    drive_req(rd, wr, exc, a, wd, m);
            else if (k == d && keep_next)  drive_req(nx_rd, nx_wr, 1'b0, nx_addr, nx_wdata, nx_mask);
            else                           drive_req(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
            bus_gnt = (k == 1 + g);
            // stray rvalid during REQ and DONE must be ignored
            bus_rvalid = (r >= 0 && k == 2 + g + r) || (k >= 1 && k <= 1 + g) || (k == d);
            bus_rdata = (r >= 0 && k == 2 + g + r) ? rbus : 32'hA5A5_5A5A;
            exp_stall   = (k < d);
            exp_done    = (k == d);
            exp_bus_err = (k == d) && err;
            exp_bus_req = (k >= 1) && (k <= 1 + g) && (k < d);
            exp_bus_we  = exp_bus_req && we;
            exp_bus_be  = exp_bus_req ? m : 4'b0000;
            exp_bus_addr  = (k == 0) ? model_addr  : lat_addr;
            exp_bus_wdata = (k == 0) ? model_wdata : wd;
            exp_rdata = (k >= d && !we) ? (err ? 32'd0 : rbus) : model_rdata;
            chk_en = 1;
            next_cycle();
        end
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        if (!keep_next) drive_req(0, 0, 0, 0, 0, 0);
        model_addr = lat_addr;
        model_wdata = wd;
        if (!we) model_rdata = err ? 32'd0 : rbus;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) next_cycle();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        rst_n = 1;
        next_cycle();

        // minimum-latency read
        run_txn(1, 0, 0, 32'h104, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
        chk_en = 0;
        chk("lit_read_rdata", rdata, 32'hDEAD_BEEF);
        chk("lit_read_addr", bus_addr, 32'h0000_0104);

        // write with gnt withheld 3 cycles; rdata must not change
        run_txn(0, 1, 0, 32'h20, 32'h0000_00AB, 4'b0001, 3, 1, 32'h0, 0);
        chk_en = 0;
        chk("lit_write_rdata", rdata, 32'hDEAD_BEEF);
        chk("lit_write_wdata", bus_wdata, 32'h0000_00AB);

        // misaligned byte address is word-aligned on the bus
        run_txn(0, 1, 0, 32'h47, 32'h1234_5678, 4'b1100, 1, 0, 32'h0, 0);
        chk_en = 0;
        chk("lit_align_addr", bus_addr, 32'h0000_0044);

        // suppressed request
        run_txn(1, 0, 1, 32'h200, 32'h0, 4'hF, 0, 0, 32'h0, 0);

        // back-to-back: read, then a read+write (treated as write) presented during DONE
        arm_next(1, 1, 32'h90, 32'h1122_3344, 4'b1111);
        run_txn(1, 0, 0, 32'h88, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 1);
        run_txn(1, 1, 0, 32'h90, 32'h1122_3344, 4'b1111, 0, 0, 32'h0, 0);
        chk_en = 0;
        chk("lit_b2b_rdata", rdata, 32'hCAFE_F00D);

        run_txn(1, 0, 0, 32'h3C, 32'h0, 4'hF, 0, 3, 32'h0BAD_F00D, 0);

        // reset during WAIT_RSP, then a late response
        chk_en = 0;
        drive_req(1, 0, 0, 32'h300, 32'h77, 4'hF);
        next_cycle();
        drive_req(0, 0, 0, 0, 0, 0);
        bus_gnt = 1;
        next_cycle();
        bus_gnt = 0;
        next_cycle();
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_bus_addr", bus_addr, 32'd0);
        chk("rst_mid_bus_wdata", bus_wdata, 32'd0);
        next_cycle();
        rst_n = 1;
        bus_rvalid = 1;
        bus_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rvalid_done", {31'd0, done}, 32'd0);
            chk("late_rvalid_rdata", rdata, 32'd0);
            chk("late_rvalid_stall", {31'd0, stall}, 32'd0);
            #4;
            bus_rvalid = 0;
        end
        model_addr = 0; model_wdata = 0; model_rdata = 0;
        next_cycle();

        run_txn(1, 0, 0, 32'h400, 32'h0, 4'hF, 2, 0, 32'h5A5A_0001, 0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // gnt but no response: bus_err with done, read returns zero
        run_txn(1, 0, 0, 32'h500, 32'h0, 4'hF, 0, -1, 32'h0, 0);
        chk_en = 0;
        chk("lit_tmo_rdata", rdata, 32'd0);
        // no gnt at all on a write; rdata held
        run_txn(1, 0, 0, 32'h504, 32'h0, 4'hF, 0, 0, 32'h0000_0F0F, 0);
        run_txn(0, 1, 0, 32'h508, 32'h99, 4'b0011, 10, -1, 32'h0, 0);
        chk_en = 0;
        chk("lit_tmo_wr_rdata", rdata, 32'h0000_0F0F);
`endif

        chk_en = 0;
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: response watchdog limit in cycles, legal range 2..65535.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 req_read  in  1  load request from the memory controller stage.
REQ-005 req_write  in  1  store request from the memory controller stage.
REQ-006 req_exception  in  1  misaligned-access flag from the controller; a flagged request is suppressed.
REQ-007 req_addr  in  32  byte address; bits [1:0] are forced to 0 on the bus.
REQ-008 req_wdata  in  32  store data.
REQ-009 req_mask  in  4  byte-enable mask.
REQ-010 stall  out  1  freezes the pipeline while an access is outstanding.
REQ-011 done  out  1  one-cycle pulse marking access completion.
REQ-012 rdata  out  32  word returned to the controller (its dataMemOut).
REQ-013 bus_req, bus_we  out  1 each  bus request and write strobe.
REQ-014 bus_addr, bus_wdata  out  32 each;  bus_be  out  4  bus payload.
REQ-015 bus_gnt, bus_rvalid  in  1 each;  bus_rdata  in  32  bus handshake and read data.
REQ-016 bus_err  out  1  one-cycle pulse on watchdog timeout.

Function
REQ-017 FSM states: IDLE, REQ, WAIT_RSP, DONE.
REQ-018 IDLE: if (req_read|req_write)&!req_exception, latch addr/wdata/mask and we=req_write, then go to REQ; otherwise stay.
REQ-019 If req_read and req_write are both high, the access is a write.
REQ-020 stall = 1 combinationally in IDLE when an accepted request is present, and in REQ and WAIT_RSP; stall = 0 in DONE.
REQ-021 REQ: bus_req = 1 with the latched payload held stable until bus_gnt; on bus_gnt go to WAIT_RSP.
REQ-022 bus_rvalid is sampled only in WAIT_RSP; in other states it is ignored.
REQ-023 WAIT_RSP: on bus_rvalid go to DONE; for reads, rdata <= bus_rdata; for writes, rdata is unchanged.
REQ-024 DONE: done = 1 for one cycle, request inputs are ignored, and the next state is IDLE.
REQ-025 Minimum latency (read, immediate gnt, rvalid the following cycle):
  - accept in cycle 0;
  - bus_req in cycle 1;
  - WAIT_RSP in cycle 2;
  - done and stall=0 in cycle 3.
REQ-026 bus_req, bus_we and bus_be are 0 outside REQ; bus_addr and bus_wdata hold their last latched values.
REQ-027 A suppressed request (req_exception=1) produces no bus activity, no stall and no done.

Reset
REQ-028 rst_n low immediately forces all of the following, including mid-access:
  - state = IDLE;
  - bus_req = bus_we = 0, bus_be = 0;
  - stall = done = bus_err = 0;
  - rdata = 0, bus_addr = bus_wdata = 0.
REQ-029 A bus_rvalid arriving after reset, for an access aborted by reset, is ignored.

Configuration
REQ-030 Macro MEM_BRIDGE_TIMEOUT_EN.
  - Defined:
    - a 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP;
    - when it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1 and done=1 for one cycle, and rdata=0 for reads.
  - Undefined: no counter; bus_err is tied to 0 and the FSM waits indefinitely.

Verification
REQ-031 Read addr 0x104, gnt in cycle 1, rvalid with 0xDEADBEEF in cycle 2 -> done in cycle 3, rdata=0xDEADBEEF, stall high in cycles 0-2.
REQ-032 Write addr 0x20, wdata 0x000000AB, mask 0001, gnt delayed 3 cycles -> bus_req and payload stable 4 cycles, bus_we=1, bus_be=0001, rdata unchanged.
REQ-033 req_read=1 with req_exception=1 -> bus_req stays 0, stall=0, done=0.
REQ-034 rst_n pulsed low while in WAIT_RSP, then rvalid arrives -> state IDLE, no done, rdata=0.
REQ-035 With MEM_BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, gnt given but no rvalid -> bus_err and done pulse together 4 cycles after entry to REQ, rdata=0.
REQ-036 Back-to-back read then write -> the second request is accepted in the IDLE cycle after DONE and is not taken during DONE.
